fgen: RTL and testbench

FGEN -- requirements
Module: fgen

---
 rtl/fgen_pkg.sv | 19 +
 rtl/fgen_if.sv | 23 ++
 rtl/fgen_phase_acc.sv | 49 ++++
 rtl/fgen.sv | 107 ++++++++++
 tb/tb_fgen.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fgen_pkg.sv
// Shared constants, widths and FSM encoding for the square-wave frequency generator.
package fgen_pkg;

  localparam int F_CLK_DFLT = 40000;  // clock frequency, hundreds of Hz
  localparam int F_MAX_DFLT = 15000;  // largest accepted frequency word
  localparam int ACC_W      = 17;     // phase accumulator width
  localparam int FW_W       = 14;     // frequency word width

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Accumulator increment is twice the frequency word: one toggle per wrap.
  function automatic logic [ACC_W-1:0] inc_of(input logic [FW_W-1:0] f);
    return {{(ACC_W-FW_W-1){1'b0}}, f, 1'b0};
  endfunction

endpackage

// File: rtl/fgen_if.sv
// Frequency-load handshake and generated-signal outputs of fgen.
interface fgen_if;
  import fgen_pkg::*;

  logic [FW_W-1:0] f_in;
  logic            f_load;
  logic            busy;
  logic            f_ack;
  logic            err;
  logic            sig;
  logic            sig_rise;

  modport master (
    output f_in, f_load,
    input  busy, f_ack, err, sig, sig_rise
  );

  modport slave (
    input  f_in, f_load,
    output busy, f_ack, err, sig, sig_rise
  );

endinterface

// File: rtl/fgen_phase_acc.sv
// Modulo-F_CLK phase accumulator; sig toggles on every wrap, sig_rise marks 0->1.
// Outputs are registered (1 cycle after the wrapping step); i_clr forces acc/sig low.
module fgen_phase_acc
  import fgen_pkg::*;
#(
  parameter int F_CLK = F_CLK_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_run,
  input  logic             i_clr,
  input  logic [ACC_W-1:0] i_inc,
  output logic             o_wrap,
  output logic             o_sig,
  output logic             o_sig_rise
);

  logic [ACC_W-1:0] r_acc;
  logic             r_sig;
  logic             r_sig_rise;
  logic [ACC_W-1:0] w_sum;
  logic             w_wrap;

  assign w_sum  = r_acc + i_inc;
  assign w_wrap = i_run && (w_sum >= ACC_W'(F_CLK));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_sig      <= 1'b0;
      r_sig_rise <= 1'b0;
    end else if (i_clr) begin
      r_acc      <= '0;
      r_sig      <= 1'b0;
      r_sig_rise <= 1'b0;
    end else if (i_run) begin
      r_acc      <= w_wrap ? (w_sum - ACC_W'(F_CLK)) : w_sum;
      r_sig      <= r_sig ^ w_wrap;
      r_sig_rise <= w_wrap & ~r_sig;
    end else begin
      r_sig_rise <= 1'b0;
    end
  end

  assign o_wrap     = w_wrap;
  assign o_sig      = r_sig;
  assign o_sig_rise = r_sig_rise;

endmodule

// File: rtl/fgen.sv
// Square-wave generator: accepted words apply 1 cycle after busy in IDLE, or at the next
// falling edge of sig in RUN; no backpressure, a later load simply overwrites the pending word.
module fgen
  import fgen_pkg::*;
#(
  parameter int F_CLK = F_CLK_DFLT,
  parameter int F_MAX = F_MAX_DFLT
) (
  input logic  clk,
  input logic  reset,
  fgen_if.slave fg
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [FW_W-1:0]  r_pend;
  logic [ACC_W-1:0] r_inc;
  logic             r_busy;
  logic             r_f_ack;
  logic             r_err;

  logic w_load_ok;
  logic w_load_bad;
  logic w_apply;
  logic w_clr;
  logic w_run;
  logic w_wrap;
  logic w_sig;
  logic w_sig_rise;

  assign w_load_ok  = fg.f_load && (fg.f_in <= FW_W'(F_MAX));
  assign w_load_bad = fg.f_load && !w_load_ok;
  assign w_run      = (r_state == RUN);
  // A zero word parks the generator: accumulator and sig are forced low.
  assign w_clr      = w_apply && (r_pend == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_apply     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_busy) begin
          w_apply     = 1'b1;
          w_state_nxt = (r_pend != '0) ? RUN : IDLE;
        end
      end
      RUN: begin
        // Only switch on a 1->0 toggle so the output never shows a runt pulse.
        if (r_busy && w_wrap && w_sig) begin
          w_apply = 1'b1;
          if (r_pend == '0) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend  <= '0;
      r_inc   <= '0;
      r_busy  <= 1'b0;
      r_f_ack <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_f_ack <= w_apply;
      r_err   <= w_load_bad;
      r_busy  <= w_load_ok | (r_busy & ~w_apply);
      if (w_load_ok) begin
        r_pend <= fg.f_in;
      end
      if (w_apply) begin
        r_inc <= inc_of(r_pend);
      end
    end
  end

  fgen_phase_acc #(
    .F_CLK(F_CLK)
  ) u_phase_acc (
    .clk       (clk),
    .reset     (reset),
    .i_run     (w_run),
    .i_clr     (w_clr),
    .i_inc     (r_inc),
    .o_wrap    (w_wrap),
    .o_sig     (w_sig),
    .o_sig_rise(w_sig_rise)
  );

  assign fg.busy     = r_busy;
  assign fg.f_ack    = r_f_ack;
  assign fg.err      = r_err;
  assign fg.sig      = w_sig;
  assign fg.sig_rise = w_sig_rise;

endmodule

// File: tb/tb_fgen.sv
// Randomised and directed bench for fgen against a closed-form phase/pending-word model.
module tb_fgen;

  localparam int F_CLK = 40000;
  localparam int F_MAX = 15000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n = 0;

  // Model: sig after j cycles since the last application is the parity of
  // floor((a0 + j*inc)/F_CLK); pending loads become eligible two cycles after the strobe.
  longint m_a0;
  int     m_inc;
  int     m_start;
  int     rej_cyc;
  int     q_val[$];
  int     q_cyc[$];
  bit     e_busy, e_ack, e_err, e_sig, e_rise;

  fgen_if fg();

  fgen #(.F_CLK(F_CLK), .F_MAX(F_MAX)) dut (
    .clk  (clk),
    .reset(reset),
    .fg   (fg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", n);
    $fatal(1, "watchdog");
  end

  function automatic bit msig(input int j);
    longint t;
    if (j < 0) return 1'b0;
    t = (m_a0 + longint'(j) * m_inc) / F_CLK;
    return t[0];
  endfunction

  function automatic void model_eval();
    int j;
    int last;
    int val;
    j = n - m_start;
    last = -1;
    e_ack = 1'b0;
    foreach (q_cyc[k]) if (q_cyc[k] <= n - 2) last = k;
    if (last >= 0 && (m_inc == 0 || (msig(j - 1) && !msig(j)))) begin
      val = q_val[last];
      m_a0 = (m_inc == 0 || val == 0) ? 64'sd0 : (m_a0 + longint'(j) * m_inc) % F_CLK;
      m_inc = 2 * val;
      m_start = n;
      e_ack = 1'b1;
      for (int k = 0; k <= last; k++) begin
        void'(q_val.pop_front());
        void'(q_cyc.pop_front());
      end
    end
    j = n - m_start;
    e_sig  = msig(j);
    e_rise = (j > 0) && msig(j) && !msig(j - 1);
    e_busy = (q_cyc.size() > 0) && (q_cyc[0] <= n - 1);
    e_err  = (rej_cyc == n - 1);
  endfunction

  function automatic void model_reset();
    q_val.delete();
    q_cyc.delete();
    m_a0 = 0;
    m_inc = 0;
    m_start = n;
    rej_cyc = -100;
    model_eval();
  endfunction

  function automatic logic [4:0] expv();
    return {e_busy, e_ack, e_err, e_sig, e_rise};
  endfunction

  function automatic logic [4:0] obsv();
    return {fg.busy, fg.f_ack, fg.err, fg.sig, fg.sig_rise};
  endfunction

  // Drive one cycle of stimulus, move to the next sample point, update expectations.
  task automatic advance(input bit ld, input int f);
    fg.f_load = ld;
    fg.f_in   = 14'(f);
    if (ld) begin
      if (f > F_MAX) rej_cyc = n;
      else begin
        q_val.push_back(f);
        q_cyc.push_back(n);
      end
    end
    @(negedge clk);
    n++;
    model_eval();
  endtask

  task automatic test_reset();
    fg.f_load = 1'b0;
    fg.f_in   = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    n = 0;
    checks++; if (fg.busy !== 1'b0)     begin $display("FAIL reset_busy got=%b want=0", fg.busy); errors++; end
    checks++; if (fg.f_ack !== 1'b0)    begin $display("FAIL reset_ack got=%b want=0", fg.f_ack); errors++; end
    checks++; if (fg.err !== 1'b0)      begin $display("FAIL reset_err got=%b want=0", fg.err); errors++; end
    checks++; if (fg.sig !== 1'b0)      begin $display("FAIL reset_sig got=%b want=0", fg.sig); errors++; end
    checks++; if (fg.sig_rise !== 1'b0) begin $display("FAIL reset_rise got=%b want=0", fg.sig_rise); errors++; end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      advance(1'b0, 0);
      checks++;
      if (obsv() !== expv()) begin
        $display("FAIL idle cyc=%0d busy/ack/err/sig/rise got=%b want=%b", n, obsv(), expv());
        errors++;
      end
    end
  endtask

  task automatic test_start();
    int ld_cyc, ack_cyc, r0, r1, f0;
    bit bad;
    ld_cyc = n; ack_cyc = -1; r0 = -1; r1 = -1; f0 = -1; bad = 1'b0;
    advance(1'b1, 10);
    for (int i = 0; i < 8200 && !bad; i++) begin
      checks++;
      if (obsv() !== expv()) begin
        $display("FAIL start cyc=%0d busy/ack/err/sig/rise got=%b want=%b", n, obsv(), expv());
        errors++; bad = 1'b1;
      end
      if (fg.f_ack && ack_cyc < 0) ack_cyc = n;
      if (fg.sig_rise) begin
        if (r0 < 0) r0 = n;
        else if (r1 < 0) r1 = n;
      end
      if (!fg.sig && r0 >= 0 && f0 < 0) f0 = n;
      advance(1'b0, 0);
    end
    checks++; if (ack_cyc - ld_cyc !== 2) begin $display("FAIL start_ack_latency got=%0d want=2", ack_cyc - ld_cyc); errors++; end
    checks++; if (r1 - r0 !== 4000)       begin $display("FAIL start_period got=%0d want=4000", r1 - r0); errors++; end
    checks++; if (f0 - r0 !== 2000)       begin $display("FAIL start_high got=%0d want=2000", f0 - r0); errors++; end
  endtask

  task automatic test_change();
    int ack_cyc, ra0, ra1, waited;
    bit bad, prev, ack_prev, ack_sig;
    ack_cyc = -1; ra0 = -1; ra1 = -1; bad = 1'b0; ack_prev = 1'b0; ack_sig = 1'b1;
    waited = 0;
    while (!fg.sig && waited < 5000) begin advance(1'b0, 0); waited++; end
    checks++; if (fg.sig !== 1'b1) begin $display("FAIL change_wait_high got=%b want=1", fg.sig); errors++; end
    repeat (500) advance(1'b0, 0);
    prev = fg.sig;
    advance(1'b1, 20);
    for (int i = 0; i < 6000 && !bad; i++) begin
      checks++;
      if (obsv() !== expv()) begin
        $display("FAIL change cyc=%0d busy/ack/err/sig/rise got=%b want=%b", n, obsv(), expv());
        errors++; bad = 1'b1;
      end
      if (fg.f_ack && ack_cyc < 0) begin ack_cyc = n; ack_prev = prev; ack_sig = fg.sig; end
      if (fg.sig_rise && ack_cyc >= 0) begin
        if (ra0 < 0) ra0 = n;
        else if (ra1 < 0) ra1 = n;
      end
      prev = fg.sig;
      advance(1'b0, 0);
    end
    checks++; if ({ack_prev, ack_sig} !== 2'b10) begin $display("FAIL change_ack_on_fall got=%b want=10", {ack_prev, ack_sig}); errors++; end
    checks++; if (ra0 - ack_cyc !== 1000) begin $display("FAIL change_first_rise got=%0d want=1000", ra0 - ack_cyc); errors++; end
    checks++; if (ra1 - ra0 !== 2000)     begin $display("FAIL change_period got=%0d want=2000", ra1 - ra0); errors++; end
  endtask

  task automatic test_double();
    int acks, ack_cyc, ra0, ra1;
    bit bad;
    acks = 0; ack_cyc = -1; ra0 = -1; ra1 = -1; bad = 1'b0;
    advance(1'b1, 10);
    for (int i = 0; i < 5000 && !bad; i++) begin
      checks++;
      if (obsv() !== expv()) begin
        $display("FAIL double cyc=%0d busy/ack/err/sig/rise got=%b want=%b", n, obsv(), expv());
        errors++; bad = 1'b1;
      end
      if (fg.f_ack) begin acks++; ack_cyc = n; end
      if (fg.sig_rise && ack_cyc >= 0) begin
        if (ra0 < 0) ra0 = n;
        else if (ra1 < 0) ra1 = n;
      end
      advance(i == 2, 40);
    end
    checks++; if (acks !== 1)         begin $display("FAIL double_ack_count got=%0d want=1", acks); errors++; end
    checks++; if (ra1 - ra0 !== 1000) begin $display("FAIL double_period got=%0d want=1000", ra1 - ra0); errors++; end
  endtask

  task automatic test_stop();
    int ack_cyc, rises, highs;
    bit bad, prev, ack_prev;
    ack_cyc = -1; rises = 0; highs = 0; bad = 1'b0; ack_prev = 1'b0;
    prev = fg.sig;
    advance(1'b1, 0);
    for (int i = 0; i < 4000 && !bad; i++) begin
      checks++;
      if (obsv() !== expv()) begin
        $display("FAIL stop cyc=%0d busy/ack/err/sig/rise got=%b want=%b", n, obsv(), expv());
        errors++; bad = 1'b1;
      end
      if (fg.f_ack && ack_cyc < 0) begin ack_cyc = n; ack_prev = prev; end
      else if (ack_cyc >= 0) begin
        if (fg.sig_rise) rises++;
        if (fg.sig) highs++;
      end
      prev = fg.sig;
      advance(1'b0, 0);
    end
    checks++; if (ack_cyc < 0 || ack_prev !== 1'b1) begin $display("FAIL stop_ack cyc=%0d prev_sig=%b want prev_sig=1", ack_cyc, ack_prev); errors++; end
    checks++; if (rises + highs !== 0) begin $display("FAIL stop_quiet got rises=%0d highs=%0d want 0", rises, highs); errors++; end
  endtask

  task automatic test_fmax();
    int ack_cyc, toggles, run, maxlow;
    bit bad, prev;
    ack_cyc = -1; toggles = 0; run = 0; maxlow = 0; bad = 1'b0; prev = 1'b0;
    advance(1'b1, 15001);
    checks++; if ({fg.err, fg.busy, fg.sig} !== 3'b100) begin $display("FAIL fmax_reject err/busy/sig got=%b want=100", {fg.err, fg.busy, fg.sig}); errors++; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obsv() !== expv()) begin
        $display("FAIL fmax_idle cyc=%0d busy/ack/err/sig/rise got=%b want=%b", n, obsv(), expv());
        errors++;
      end
      advance(i == 2, 15000);
    end
    for (int i = 0; i < 3005 && !bad; i++) begin
      checks++;
      if (obsv() !== expv()) begin
        $display("FAIL fmax cyc=%0d busy/ack/err/sig/rise got=%b want=%b", n, obsv(), expv());
        errors++; bad = 1'b1;
      end
      if (fg.f_ack && ack_cyc < 0) ack_cyc = n;
      if (ack_cyc >= 0 && n <= ack_cyc + 3000) begin
        if (n > ack_cyc && fg.sig != prev) toggles++;
        if (!fg.sig) run++;
        else begin
          if (run > maxlow) maxlow = run;
          run = 0;
        end
      end
      prev = fg.sig;
      advance(1'b0, 0);
    end
    checks++; if (toggles !== 2250) begin $display("FAIL fmax_toggles got=%0d want=2250", toggles); errors++; end
    checks++; if (maxlow !== 2)     begin $display("FAIL fmax_max_low got=%0d want=2", maxlow); errors++; end
  endtask

  task automatic test_random();
    int sel, f;
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < 3000 && !bad; i++) begin
      checks++;
      if (obsv() !== expv()) begin
        $display("FAIL random cyc=%0d busy/ack/err/sig/rise got=%b want=%b", n, obsv(), expv());
        errors++; bad = 1'b1;
      end
      if ($urandom_range(0, 11) == 0) begin
        sel = $urandom_range(0, 9);
        if (sel < 7)       f = $urandom_range(4000, 15000);
        else if (sel == 7) f = 0;
        else if (sel == 8) f = $urandom_range(15001, 16383);
        else               f = 15000;
        advance(1'b1, f);
      end else begin
        advance(1'b0, 0);
      end
    end
  endtask

  task automatic test_reset_busy();
    int waited, acks, highs;
    bit bad;
    acks = 0; highs = 0; bad = 1'b0; waited = 0;
    advance(1'b1, 10);
    while (m_inc != 20 && waited < 500) begin advance(1'b0, 0); waited++; end
    waited = 0;
    while (!fg.sig && waited < 3000) begin advance(1'b0, 0); waited++; end
    repeat (100) advance(1'b0, 0);
    advance(1'b1, 20);
    fg.f_load = 1'b0;
    checks++; if ({fg.busy, fg.sig} !== 2'b11) begin $display("FAIL rstbusy_pre busy/sig got=%b want=11", {fg.busy, fg.sig}); errors++; end
    #2 reset = 1'b1;
    #1;
    checks++; if (obsv() !== 5'b0) begin $display("FAIL rstbusy_async got=%b want=00000", obsv()); errors++; end
    @(negedge clk); n++;
    @(negedge clk); n++;
    checks++; if (obsv() !== 5'b0) begin $display("FAIL rstbusy_held got=%b want=00000", obsv()); errors++; end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3000 && !bad; i++) begin
      checks++;
      if (obsv() !== expv()) begin
        $display("FAIL rstbusy cyc=%0d busy/ack/err/sig/rise got=%b want=%b", n, obsv(), expv());
        errors++; bad = 1'b1;
      end
      if (fg.f_ack) acks++;
      if (fg.sig) highs++;
      advance(1'b0, 0);
    end
    checks++; if (acks + highs !== 0) begin $display("FAIL rstbusy_quiet got acks=%0d highs=%0d want 0", acks, highs); errors++; end
  endtask

  initial begin
    fg.f_load = 1'b0;
    fg.f_in   = '0;
    test_reset();
    test_start();
    test_change();
    test_double();
    test_stop();
    test_fmax();
    test_random();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
